// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register and condition-code evaluation against the stored flags.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  output logic       CondEx
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    case (cond_t'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~(c & ~z);
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] & CondEx) flags_d[3:2] = ALUFlags[3:2];
    if (FlagW[0] & CondEx) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM with memory wait counter and ALU decoder.
// Optional CTRL_CMP_EN: decode cmd 1010 as CMP (SUB, flags only, no register write).
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        last_wait;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        next_pc, ir_w, reg_w, mem_w, branch, alu_op;
  logic        no_write, cond_ex;
  logic [1:0]  flag_w;
  logic        unused_instr;

  assign op           = Instr[15:14];
  assign funct        = Instr[13:8];
  assign unused_instr = ^Instr[7:0];
  assign last_wait    = (wait_q == 3'(MEM_WAIT));

  always_ff @(posedge clk) begin
    state_q <= state_d;
    wait_q  <= wait_d;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      FETCH:    if (last_wait) state_d = DECODE; else wait_d = wait_q + 3'd1;
      DECODE: begin
        case (op)
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:    if (last_wait) state_d = MEMWB; else wait_d = wait_q + 3'd1;
      MEMWR:    if (last_wait) state_d = FETCH; else wait_d = wait_q + 3'd1;
      EXECUTER,
      EXECUTEI: state_d = no_write ? FETCH : ALUWB;
      default:  state_d = FETCH;
    endcase
    if (reset) begin
      state_d = FETCH;
      wait_d  = '0;
    end
  end

  always_comb begin
    next_pc   = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      FETCH: begin
        next_pc   = last_wait;
        ir_w      = last_wait;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = last_wait;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        alu_op  = 1'b1;
        ALUSrcB = 2'b01;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Unknown commands fall back to ADD with no register or flag write.
  always_comb begin
    ALUControl = ALU_ADD;
    no_write   = 1'b0;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: flag_w = {funct[0], funct[0]};
        4'b0010: begin ALUControl = ALU_SUB; flag_w = {funct[0], funct[0]}; end
        4'b0000: begin ALUControl = ALU_AND; flag_w = {funct[0], 1'b0}; end
        4'b1100: begin ALUControl = ALU_ORR; flag_w = {funct[0], 1'b0}; end
`ifdef CTRL_CMP_EN
        4'b1010: begin
          ALUControl = ALU_SUB;
          no_write   = 1'b1;
          flag_w     = {funct[0], funct[0]};
        end
`endif
        default: no_write = 1'b1;
      endcase
    end
  end

  cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Instr[19:16]),
    .ALUFlags (ALUFlags),
    .FlagW    (flag_w),
    .CondEx   (cond_ex)
  );

  assign ImmSrc   = op;
  assign RegSrc   = {op == IMM_MEM, op == IMM_BR};
  assign IRWrite  = ir_w & ~reset;
  assign RegWrite = reg_w & cond_ex & ~reset;
  assign MemWrite = mem_w & cond_ex & ~reset;
  assign PCWrite  = (next_pc | (branch & cond_ex)) & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected output sequences built from the control rules.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;

  logic        pcw0, memw0, regw0, irw0, adr0, srca0;
  logic [1:0]  rsrc0, srcb0, res0, imm0, alu0;
  logic        pcw1, memw1, regw1, irw1, adr1, srca1;
  logic [1:0]  rsrc1, srcb1, res1, imm1, alu1;
  logic [15:0] vec0, vec1;

  int checks = 0;
  int failures = 0;
  logic [3:0]  mflags = '0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  string       nm_q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT(0)) dut (
    .clk(clk), .reset(rst0), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(pcw0), .MemWrite(memw0), .RegWrite(regw0), .IRWrite(irw0),
    .AdrSrc(adr0), .RegSrc(rsrc0), .ALUSrcA(srca0), .ALUSrcB(srcb0),
    .ResultSrc(res0), .ImmSrc(imm0), .ALUControl(alu0)
  );

  multicycle_controller #(.MEM_WAIT(2)) dut_w (
    .clk(clk), .reset(rst1), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(pcw1), .MemWrite(memw1), .RegWrite(regw1), .IRWrite(irw1),
    .AdrSrc(adr1), .RegSrc(rsrc1), .ALUSrcA(srca1), .ALUSrcB(srcb1),
    .ResultSrc(res1), .ImmSrc(imm1), .ALUControl(alu1)
  );

  assign vec0 = {pcw0, memw0, regw0, irw0, adr0, rsrc0, srca0, srcb0, res0, imm0, alu0};
  assign vec1 = {pcw1, memw1, regw1, irw1, adr1, rsrc1, srca1, srcb1, res1, imm1, alu1};

  function automatic logic [15:0] mkv(input bit pcw, input bit memw, input bit regw, input bit irw,
                                      input bit adr, input logic [1:0] rsrc, input bit srca,
                                      input logic [1:0] srcb, input logic [1:0] res,
                                      input logic [1:0] imm, input logic [1:0] alu);
    return {pcw, memw, regw, irw, adr, rsrc, srca, srcb, res, imm, alu};
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] fl);
    bit n = fl[3], z = fl[2], cy = fl[1], v = fl[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // {ALUControl, NoWrite, FlagW}
  function automatic logic [4:0] alu_dec(input logic [5:0] f);
    bit s = f[0];
    case (f[4:1])
      4'b0100: return {2'b00, 1'b0, s, s};
      4'b0010: return {2'b01, 1'b0, s, s};
      4'b0000: return {2'b10, 1'b0, s, 1'b0};
      4'b1100: return {2'b11, 1'b0, s, 1'b0};
`ifdef CTRL_CMP_EN
      4'b1010: return {2'b01, 1'b1, s, s};
`endif
      default: return {2'b00, 1'b1, 2'b00};
    endcase
  endfunction

  // Drives one instruction and records expected/observed vectors per cycle.
  // abort_at: cycle index where reset is raised (-1 = none).
  task automatic run_instr(input bit sel, input logic [19:0] ins, input logic [3:0] af,
                           input int abort_at);
    int          w = sel ? 2 : 0;
    logic [3:0]  cond = ins[19:16];
    logic [1:0]  op = ins[15:14];
    logic [5:0]  f = ins[13:8];
    logic [1:0]  rs = {op == 2'b01, op == 2'b10};
    bit          ce = cond_ok(cond, mflags);
    logic [3:0]  nfl = mflags;
    logic [4:0]  d;
    logic [15:0] e;
    exp_q.delete(); obs_q.delete(); nm_q.delete();
    for (int k = 0; k <= w; k++) begin
      exp_q.push_back(mkv(k == w, 0, 0, k == w, 0, rs, 1, 2'b10, 2'b10, op, 2'b00));
      nm_q.push_back("fetch");
    end
    exp_q.push_back(mkv(0, 0, 0, 0, 0, rs, 1, 2'b10, 2'b10, op, 2'b00)); nm_q.push_back("decode");
    if (op == 2'b01) begin
      exp_q.push_back(mkv(0, 0, 0, 0, 0, rs, 0, 2'b01, 2'b00, op, 2'b00)); nm_q.push_back("memadr");
      for (int k = 0; k <= w; k++) begin
        exp_q.push_back(mkv(0, !f[0] && ce && k == w, 0, 0, 1, rs, 0, 2'b00, 2'b00, op, 2'b00));
        nm_q.push_back(f[0] ? "memrd" : "memwr");
      end
      if (f[0]) begin
        exp_q.push_back(mkv(0, 0, ce, 0, 0, rs, 0, 2'b00, 2'b01, op, 2'b00)); nm_q.push_back("memwb");
      end
    end else if (op == 2'b10) begin
      exp_q.push_back(mkv(ce, 0, 0, 0, 0, rs, 0, 2'b01, 2'b10, op, 2'b00)); nm_q.push_back("branch");
    end else if (op == 2'b00) begin
      d = alu_dec(f);
      exp_q.push_back(mkv(0, 0, 0, 0, 0, rs, 0, f[5] ? 2'b01 : 2'b00, 2'b00, op, d[4:3]));
      nm_q.push_back("execute");
      if (ce && d[1]) nfl[3:2] = af[3:2];
      if (ce && d[0]) nfl[1:0] = af[1:0];
      if (!d[2]) begin
        // Writeback sees the flags just written by the execute step.
        exp_q.push_back(mkv(0, 0, cond_ok(cond, nfl), 0, 0, rs, 0, 2'b00, 2'b00, op, 2'b00));
        nm_q.push_back("aluwb");
      end
    end
    Instr = ins;
    ALUFlags = af;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        e = exp_q[i];
        e[15:12] = 4'b0000;
        exp_q[i] = e;
        nm_q[i] = "reset_abort";
        if (sel) rst1 = 1'b1; else rst0 = 1'b1;
      end
      @(negedge clk);
      obs_q.push_back(sel ? vec1 : vec0);
      @(posedge clk); #1;
      if (i == abort_at) begin
        if (sel) rst1 = 1'b0; else rst0 = 1'b0;
        mflags = '0;
        while (exp_q.size() > obs_q.size()) begin
          void'(exp_q.pop_back());
          void'(nm_q.pop_back());
        end
        return;
      end
    end
    mflags = nfl;
  endtask

  task automatic test_reset();
    logic [15:0] exp_v = mkv(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b10, 2'b00, 2'b00);
    rst0 = 1'b1; Instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (vec0 !== exp_v) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", vec0, exp_v);
    end
    @(posedge clk); #1;
    rst0 = 1'b0;
    mflags = '0;
  endtask

  task automatic test_add();
    run_instr(0, 20'hE0821, 4'h0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL add_%s[%0d]: got %h expected %h", nm_q[i], i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (exp_q.size() != 4 || obs_q[3][13] !== 1'b1) begin
      failures++;
      $display("FAIL add_regwrite_in_aluwb: got len %0d rw %b expected len 4 rw 1",
               exp_q.size(), obs_q[3][13]);
    end
  endtask

  task automatic test_ldr();
    run_instr(0, 20'hE5921, 4'h0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ldr_%s[%0d]: got %h expected %h", nm_q[i], i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch_cond();
    logic [3:0] zf[2] = '{4'b0100, 4'b0000};
    for (int r = 0; r < 2; r++) begin
      run_instr(0, 20'hE0521, zf[r], -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL subs%0d_%s[%0d]: got %h expected %h", r, nm_q[i], i, obs_q[i], exp_q[i]);
        end
      end
      run_instr(0, 20'h0A000, 4'h0, -1);
      checks++;
      if (obs_q[2][15] !== (r == 0)) begin
        failures++;
        $display("FAIL beq%0d_pcwrite: got %b expected %b", r, obs_q[2][15], r == 0);
      end
      checks++;
      if (obs_q[2][3:2] !== 2'b10) begin
        failures++;
        $display("FAIL beq%0d_immsrc: got %b expected 10", r, obs_q[2][3:2]);
      end
    end
  endtask

  task automatic test_reset_in_memwr();
    run_instr(0, 20'hE0521, 4'b0110, -1);
    run_instr(0, 20'hE5821, 4'h0, 3);
    checks++;
    if (obs_q.size() != 4 || obs_q[3] !== exp_q[3]) begin
      failures++;
      $display("FAIL memwr_reset: got %h expected %h", obs_q[obs_q.size()-1], exp_q[3]);
    end
    run_instr(0, 20'h0A000, 4'h0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL post_reset_beq_%s[%0d]: got %h expected %h", nm_q[i], i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cmp();
    logic [19:0] probes[4] = '{20'h0A000, 20'h2A000, 20'h4A000, 20'h6A000};
    run_instr(0, 20'hE0521, 4'b0000, -1);
    run_instr(0, 20'hE1510, 4'b0110, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][13] !== 1'b0) begin
        failures++;
        $display("FAIL cmp_%s[%0d]: got %h expected %h", nm_q[i], i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (exp_q.size() != 3) begin
      failures++;
      $display("FAIL cmp_length: got %0d expected 3", exp_q.size());
    end
    foreach (probes[p]) begin
      run_instr(0, probes[p], 4'h0, -1);
      checks++;
      if (obs_q[2] !== exp_q[2]) begin
        failures++;
        $display("FAIL cmp_flag_probe%0d: got %h expected %h", p, obs_q[2], exp_q[2]);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] ins;
    int          ab;
    for (int n = 0; n < 250; n++) begin
      ins = 20'($urandom);
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(0, ins, 4'($urandom), ab);
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_%h_%s[%0d]: got %h expected %h",
                   n, ins, nm_q[i], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [19:0] seq[3] = '{20'hE0821, 20'hE5821, 20'hE5921};
    int          irw_pulses, mw_pulses;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    mflags = '0;
    foreach (seq[s]) begin
      run_instr(1, seq[s], 4'h0, -1);
      irw_pulses = 0;
      mw_pulses = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        irw_pulses += int'(obs_q[i][12]);
        mw_pulses += int'(obs_q[i][14]);
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL wait_%h_%s[%0d]: got %h expected %h", seq[s], nm_q[i], i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (irw_pulses != 1 || obs_q[2][12] !== 1'b1) begin
        failures++;
        $display("FAIL wait_irwrite_pulse: got %0d pulses expected 1 on fetch cycle 3", irw_pulses);
      end
      checks++;
      if (mw_pulses != (s == 1 ? 1 : 0)) begin
        failures++;
        $display("FAIL wait_memwrite_pulse: got %0d expected %0d", mw_pulses, s == 1 ? 1 : 0);
      end
    end
    for (int n = 0; n < 40; n++) begin
      run_instr(1, 20'($urandom), 4'($urandom), -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL wait_rand%0d_%s[%0d]: got %h expected %h", n, nm_q[i], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_branch_cond();
    test_reset_in_memwr();
    test_cmp();
    test_random();
    test_mem_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
